// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core memory arbiter.
package riscv_pkg;

  localparam int XLEN = 16;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Read data returned to the owner when the watchdog gives up on memory.
  localparam logic [XLEN-1:0] TIMEOUT_RDATA = '0;

endpackage

// File: rtl/riscv_arb_pick.sv
// Combinational winner select between fetch (IF) and load/store (LS).
// RISCV_ARB_RR_EN selects round-robin; otherwise LS has fixed priority.
module riscv_arb_pick
  import riscv_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  owner_e last_owner,
  output owner_e owner
);

`ifdef RISCV_ARB_RR_EN
  always_comb begin
    if (if_req && ls_req) begin
      owner = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
    end else if (if_req) begin
      owner = OWN_IF;
    end else begin
      owner = OWN_LS;
    end
  end
`else
  // Fixed priority has no use for history.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    owner = (if_req && !ls_req) ? OWN_IF : OWN_LS;
  end
`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter: one outstanding IF or LS access with a response watchdog.
// Define RISCV_ARB_RR_EN for round-robin arbitration (default: LS over IF).
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = XLEN,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_timeout,
  output logic          busy
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  arb_state_e    state, state_n;
  owner_e        owner, pick, last_owner;
  logic [CW-1:0] cnt;
  logic          load;
  logic          resp_done;

  riscv_arb_pick u_pick (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .last_owner (last_owner),
    .owner      (pick)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n     = state;
    load        = 1'b0;
    resp_done   = 1'b0;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    ls_rvalid   = 1'b0;
    arb_timeout = 1'b0;
    rdata       = '0;
    case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          load    = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if_gnt  = (owner == OWN_IF);
          ls_gnt  = (owner == OWN_LS);
          state_n = mem_we ? IDLE : RESP;
        end
      end
      RESP: begin
        // Real data wins over a watchdog expiry in the same cycle.
        if (mem_rvalid) begin
          resp_done = 1'b1;
          rdata     = mem_rdata;
          state_n   = IDLE;
        end else if (cnt == CNT_LAST) begin
          resp_done   = 1'b1;
          arb_timeout = 1'b1;
          rdata       = DW'(TIMEOUT_RDATA);
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (resp_done) begin
      if_rvalid = (owner == OWN_IF);
      ls_rvalid = (owner == OWN_LS);
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        owner     <= pick;
        mem_req   <= 1'b1;
        mem_we    <= (pick == OWN_LS) && ls_we;
        mem_addr  <= (pick == OWN_LS) ? ls_addr : if_addr;
        mem_wdata <= (pick == OWN_LS) ? ls_wdata : '0;
      end else if (state == REQ && mem_gnt) begin
        mem_req <= 1'b0;
      end
      // Cleared outside RESP, so every RESP visit starts from zero.
      if (state != RESP) begin
        cnt <= '0;
      end else if (!mem_rvalid && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef RISCV_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_LS;
    end else if (load) begin
      last_owner <= pick;
    end
  end
`else
  assign last_owner = OWN_LS;
`endif

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Single-port memory arbiter for the 16-bit RISC-V core. It shares one unified instruction/data memory port between the instruction-fetch requester (IF) and the load/store requester (LS). It sits between the core pipeline and the memory inside `RISCV_Top`. It serialises accesses with one outstanding transaction and routes read data back to the owner. A watchdog guarantees the pipeline never hangs on a missing response.

## Interface
- `AW`, default 16: address width.
- `DW`, default 16: data width.
- `MAX_WAIT`, default 15: maximum number of cycles spent in RESP before a timeout.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `if_req`, in, 1: fetch request; held high until `if_gnt`.
- `if_addr`, in, AW: fetch address; stable while `if_req` is high.
- `if_gnt`, out, 1: one-cycle acceptance pulse.
- `if_rvalid`, out, 1: fetch data valid, one-cycle pulse.
- `ls_req`, in, 1: load/store request; held high until `ls_gnt`.
- `ls_we`, in, 1: 1 = store, 0 = load.
- `ls_addr`, in, AW: load/store address.
- `ls_wdata`, in, DW: store data.
- `ls_gnt`, out, 1: one-cycle acceptance pulse.
- `ls_rvalid`, out, 1: load data valid, one-cycle pulse.
- `rdata`, out, DW: read data, shared by both requesters; qualified by the owner's rvalid.
- `mem_req`, out, 1: memory request, registered.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, AW: memory address.
- `mem_wdata`, out, DW: memory write data.
- `mem_gnt`, in, 1: memory accepts the request this cycle.
- `mem_rvalid`, in, 1: memory read response valid.
- `mem_rdata`, in, DW: memory read data.
- `arb_timeout`, out, 1: one-cycle pulse when the watchdog fires.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, REQ and RESP.
- IDLE, any request pending:
  - pick a winner;
  - latch owner, `we`, `addr` and `wdata` into the `mem_*` registers;
  - go to REQ.
- REQ:
  - `mem_req`=1.
  - On `mem_gnt`=1, pulse `<owner>_gnt` in the same cycle (combinational from `mem_gnt`, state and owner).
  - If the access is a write, return to IDLE; if it is a read, go to RESP.
  - The wait for `mem_gnt` is unbounded.
- RESP:
  - `mem_req`=0.
  - On `mem_rvalid`=1, pulse `<owner>_rvalid` and set `rdata`=`mem_rdata`, both combinational; go to IDLE.
  - A wait counter increments each RESP cycle without `mem_rvalid`.
  - When the counter reaches MAX_WAIT:
    - pulse `arb_timeout` and `<owner>_rvalid`;
    - set `rdata`=0;
    - go to IDLE.
- Default priority: LS over IF; a fetch waits while LS requests back-to-back.
- `mem_rvalid` is ignored in IDLE and REQ (stray responses are dropped).
- If a requester drops `req` before `gnt` (illegal), the latched transaction still completes and its pulses are issued.
- Reset values:
  - all outputs 0, including `mem_addr`, `mem_wdata` and `rdata`;
  - state IDLE;
  - counter 0.
- Reset mid-transaction drops `mem_req` asynchronously and discards the in-flight response.

## Timing
- Read, memory with zero wait states:
  - cycle 0: `req` seen in IDLE;
  - cycle 1: `mem_req` and `gnt`;
  - cycle 2: `mem_rvalid` and `rvalid`;
  - cycle 3: IDLE.
- Write, memory with zero wait states: `req` at cycle 0, `mem_req`/`gnt` at cycle 1, IDLE at cycle 2.
- One IDLE cycle always separates consecutive transactions. Peak throughput is one read per 3 cycles.
- Wait counter:
  - width $clog2(MAX_WAIT+1), saturating;
  - cleared on entry to RESP.
- Timeout fires on the MAX_WAIT-th RESP cycle. If `mem_rvalid` arrives in that same cycle, real data wins and no timeout pulse is issued.

## Configuration
- `RISCV_ARB_RR_EN` defined: round-robin arbitration.
  - A `last_owner` register (reset value LS) tracks the previous winner.
  - On simultaneous requests, the requester not granted last wins, so IF goes first after reset.
  - A single request always wins regardless of `last_owner`.
- Undefined: fixed LS-over-IF priority, and no `last_owner` register exists.

## Structure
- Package `riscv_pkg` holds:
  - `owner_e` (OWN_IF, OWN_LS);
  - `arb_state_e` (IDLE, REQ, RESP);
  - XLEN=16;
  - the timeout read-data constant (0).
- Sub-module `riscv_arb_pick` is the combinational winner select: inputs `if_req`, `ls_req`, `last_owner`; output `owner_e`. It contains the round-robin logic under the macro.

## Test plan
- IF reads 0x0040 and memory returns 0xA5A5 one cycle after `mem_gnt` → `if_gnt` at cycle 1, `if_rvalid` with `rdata`=0xA5A5 at cycle 2, `busy` low at cycle 3.
- LS stores 0x1234 to 0x0100 with `mem_gnt` delayed 3 cycles → `mem_we`=1 with address/data stable for 4 cycles, `ls_gnt` on the 4th, no `ls_rvalid`.
- IF and LS request together at every IDLE:
  - macro off: LS is granted every time;
  - macro on: grants alternate IF, LS, IF.
- IF read with `mem_rvalid` never asserted, MAX_WAIT=15 → `arb_timeout` and `if_rvalid` with `rdata`=0 on RESP cycle 15, then IDLE.
- `rst`=0 pulsed while in RESP → `mem_req` and all pulses 0 immediately; a late `mem_rvalid` after release produces no `rvalid`.
- `mem_rvalid` asserted in the same cycle the counter hits MAX_WAIT → `rvalid` carries `mem_rdata`, and `arb_timeout` stays 0.
